// File: rtl/sprite_port_bank.sv
// sprite_port_bank: double-buffered sprite attribute bank.
// Software fills the shadow bank and requests a commit. The shadow bank is
// copied into the active bank in one edge at the next frame_start, so the
// renderer never sees a half-updated frame.
// Optional feature: define SPRITE_BANK_ERRCNT_EN to count discarded
// out-of-range writes in err_count (saturating). Otherwise err_count reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | writes accepted; waiting for commit_req
// PENDING | commit requested; writes blocked; waiting for frame_start
// ACK     | swap done, commit_ack high; waiting for commit_req to drop
module sprite_port_bank #(
  parameter int NUM_SPRITES = 16,
  parameter int IDXW        = $clog2(NUM_SPRITES)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [7:0]                 wr_index,
  input  logic [31:0]                wr_data,
  input  logic                       commit_req,
  output logic                       commit_ack,
  input  logic                       frame_start,
  output logic [NUM_SPRITES*10-1:0]  xCoord_flat,
  output logic [NUM_SPRITES*10-1:0]  yCoord_flat,
  output logic [NUM_SPRITES*3-1:0]   state_flat,
  output logic [NUM_SPRITES*3-1:0]   type_flat,
  output logic [15:0]                commit_count,
  output logic [7:0]                 err_count
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

  localparam logic [7:0] NUM_SPRITES_W = 8'(NUM_SPRITES);

  state_t      state_q, state_d;
  logic        commit_ack_q, commit_ack_d;
  logic [15:0] commit_count_q, commit_count_d;
  logic [25:0] shadow_q [NUM_SPRITES];
  logic [25:0] shadow_d [NUM_SPRITES];
  logic [25:0] active_q [NUM_SPRITES];
  logic [25:0] active_d [NUM_SPRITES];

  logic            wr_accept;
  logic            wr_in_range;
  logic            swap;
  logic [IDXW-1:0] wr_slot;
  logic            unused_wr_bits;

  // wr_ready is gated by Reset so it reads 0 throughout reset and 1 as soon
  // as reset is released into IDLE, rather than one cycle later.
  assign wr_ready       = (state_q == IDLE) && !Reset;
  assign wr_accept      = wr_valid && wr_ready;
  assign wr_in_range    = wr_index < NUM_SPRITES_W;
  assign wr_slot        = wr_index[IDXW-1:0];
  assign unused_wr_bits = ^wr_data[31:26];
  assign commit_ack     = commit_ack_q;
  assign commit_count   = commit_count_q;

  // Commit handshake; a dropped request in PENDING cancels even if
  // frame_start arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      IDLE:    if (commit_req) state_d = PENDING;
      PENDING: begin
        if (!commit_req) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d = ACK;
          swap    = 1'b1;
        end
      end
      ACK:     if (!commit_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    commit_ack_d   = (state_d == ACK);
    commit_count_d = commit_count_q + 16'(swap);
  end

  // Next bank contents: shadow takes software writes, active takes the swap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_accept && wr_in_range) shadow_d[wr_slot] = wr_data[25:0];
    if (swap) active_d = shadow_q;
  end

  // State, counters and both banks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      commit_ack_q   <= 1'b0;
      commit_count_q <= 16'h0000;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      commit_ack_q   <= commit_ack_d;
      commit_count_q <= commit_count_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  // Unpack the active bank onto the flat per-channel buses.
  always_comb begin
    xCoord_flat = '0;
    yCoord_flat = '0;
    state_flat  = '0;
    type_flat   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      xCoord_flat[i*10 +: 10] = active_q[i][9:0];
      yCoord_flat[i*10 +: 10] = active_q[i][19:10];
      state_flat[i*3 +: 3]    = active_q[i][22:20];
      type_flat[i*3 +: 3]     = active_q[i][25:23];
    end
  end

`ifdef SPRITE_BANK_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Count discarded out-of-range writes, holding at 0xFF.
  always_comb begin
    err_count_d = err_count_q;
    if (wr_accept && !wr_in_range && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge Clk) begin
    if (Reset) err_count_q <= 8'h00;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_sprite_port_bank.sv
// Bench for sprite_port_bank: directed writes and commits; every swap pushes
// its expected active-bank image into a queue that a monitor checks when
// commit_ack rises.
module tb_sprite_port_bank;

`ifdef SPRITE_BANK_ERRCNT_EN
  localparam logic [7:0] ERR1    = 8'd1;
  localparam logic [7:0] ERR_SAT = 8'hFF;
`else
  localparam logic [7:0] ERR1    = 8'd0;
  localparam logic [7:0] ERR_SAT = 8'd0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic         wr_valid, wr_ready, commit_req, commit_ack, frame_start;
  logic [7:0]   wr_index, err_count;
  logic [31:0]  wr_data;
  logic [159:0] x_flat, y_flat;
  logic [47:0]  st_flat, ty_flat;
  logic [15:0]  commit_count;

  logic         w64_wr_valid, w64_wr_ready, w64_commit_req, w64_commit_ack, w64_frame_start;
  logic [7:0]   w64_wr_index, w64_err_count;
  logic [31:0]  w64_wr_data;
  logic [639:0] w64_x, w64_y;
  logic [191:0] w64_st, w64_ty;
  logic [15:0]  w64_commit_count;

  sprite_port_bank #(.NUM_SPRITES(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_data(wr_data), .commit_req(commit_req),
    .commit_ack(commit_ack), .frame_start(frame_start),
    .xCoord_flat(x_flat), .yCoord_flat(y_flat), .state_flat(st_flat),
    .type_flat(ty_flat), .commit_count(commit_count), .err_count(err_count)
  );

  sprite_port_bank #(.NUM_SPRITES(64)) u_dut64 (
    .Clk(Clk), .Reset(Reset), .wr_valid(w64_wr_valid), .wr_ready(w64_wr_ready),
    .wr_index(w64_wr_index), .wr_data(w64_wr_data), .commit_req(w64_commit_req),
    .commit_ack(w64_commit_ack), .frame_start(w64_frame_start),
    .xCoord_flat(w64_x), .yCoord_flat(w64_y), .state_flat(w64_st),
    .type_flat(w64_ty), .commit_count(w64_commit_count), .err_count(w64_err_count)
  );

  typedef struct packed {
    logic [15:0]  cnt;
    logic [159:0] x;
    logic [159:0] y;
    logic [47:0]  st;
    logic [47:0]  ty;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic bulk     = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 8) begin
      @(negedge Clk);
      #1;
      k++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, %0d swaps still expected", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic one_commit();
    commit_req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    commit_req = 1'b0;
    @(negedge Clk);
  endtask

  // Monitor: every rising commit_ack must match the oldest expected swap.
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (!bulk && commit_ack && !ack_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: got commit_ack=1 count=%0h expected no swap", commit_count);
        end else begin
          e = sb_q.pop_front();
          check("swap_count", 160'(commit_count), 160'(e.cnt));
          check("swap_x", x_flat, e.x);
          check("swap_y", y_flat, e.y);
          check("swap_state", 160'(st_flat), 160'(e.st));
          check("swap_type", 160'(ty_flat), 160'(e.ty));
        end
      end
      ack_prev = commit_ack;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    Reset = 1'b1;
    wr_valid = 0; wr_index = 0; wr_data = 0; commit_req = 0; frame_start = 0;
    w64_wr_valid = 0; w64_wr_index = 0; w64_wr_data = 0; w64_commit_req = 0; w64_frame_start = 0;
    tick(3);
    check("rst_wr_ready", 160'(wr_ready), 160'(0));
    check("rst_ack", 160'(commit_ack), 160'(0));
    check("rst_count", 160'(commit_count), 160'(0));
    check("rst_err", 160'(err_count), 160'(0));
    check("rst_x", x_flat, 160'(0));
    check("rst_y", y_flat, 160'(0));
    check("rst_st_ty", 160'({st_flat, ty_flat}), 160'(0));
    Reset = 1'b0;
    tick(1);
    check("wr_ready_after_reset", 160'(wr_ready), 160'(1));

    // 64-channel variant: top channel mapping and out-of-range index 64
    w64_wr_valid = 1; w64_wr_index = 8'd63; w64_wr_data = 32'h0113_C2A5;
    tick(1);
    w64_wr_index = 8'd64; w64_wr_data = 32'hFFFF_FFFF;
    tick(1);
    w64_wr_valid = 0; w64_commit_req = 1;
    tick(1);
    w64_frame_start = 1;
    tick(1);
    w64_frame_start = 0; w64_commit_req = 0;
    check("w64_x63", 160'(w64_x[639:630]), 160'(10'h2A5));
    check("w64_y63", 160'(w64_y[639:630]), 160'(10'h0F0));
    check("w64_st63", 160'(w64_st[191:189]), 160'(3'd1));
    check("w64_ty63", 160'(w64_ty[191:189]), 160'(3'd2));
    check("w64_x62", 160'(w64_x[629:620]), 160'(0));
    check("w64_ack", 160'(w64_commit_ack), 160'(1));
    check("w64_count", 160'(w64_commit_count), 160'(1));
    check("w64_err", 160'(w64_err_count), 160'(ERR1));
    tick(1);

    // shadow write to channel 3 is invisible until commit
    wr_valid = 1; wr_index = 8'd3; wr_data = 32'h0080_6414;
    tick(1);
    wr_valid = 0;
    tick(1);
    check("active_untouched_by_write", x_flat, 160'(0));

    // commit with frame_start 10 cycles later; write held during PENDING
    e = '0;
    e.cnt = 16'd1;
    e.x = 160'h014 << 30;
    e.y = 160'h019 << 30;
    e.ty = 48'h1 << 9;
    sb_q.push_back(e);
    commit_req = 1;
    tick(1);
    wr_valid = 1; wr_index = 8'd5; wr_data = 32'h000F_FFFF;
    tick(1);
    check("wr_ready_pending", 160'(wr_ready), 160'(0));
    tick(7);
    wr_valid = 0;
    tick(1);
    check("no_swap_before_pulse", x_flat, 160'(0));
    frame_start = 1;
    tick(1);
    frame_start = 0;
    wait_drain("commit1");
    check("wr_ready_ack", 160'(wr_ready), 160'(0));
    check("ack_held", 160'(commit_ack), 160'(1));
    commit_req = 0;
    tick(1);
    check("ack_drop", 160'(commit_ack), 160'(0));
    check("wr_ready_idle", 160'(wr_ready), 160'(1));

    // out-of-range writes: counted (or silent) and saturating
    wr_valid = 1; wr_index = 8'd16; wr_data = 32'hFFFF_FFFF;
    tick(1);
    wr_valid = 0;
    check("err_one", 160'(err_count), 160'(ERR1));
    wr_valid = 1; wr_index = 8'd200;
    tick(260);
    wr_valid = 0;
    check("err_saturate", 160'(err_count), 160'(ERR_SAT));
    check("oor_active", x_flat, 160'h014 << 30);

    // boundary channel 15 (ignored bits set), then write+commit same cycle
    wr_valid = 1; wr_index = 8'd15; wr_data = 32'hFEF0_07FF;
    tick(1);
    wr_index = 8'd0; wr_data = 32'h032A_A955; commit_req = 1;
    e.cnt = 16'd2;
    e.x = 160'h155 | (160'h014 << 30) | (160'h3FF << 150);
    e.y = 160'h2AA | (160'h019 << 30) | (160'h001 << 150);
    e.st = 48'h2 | (48'h7 << 45);
    e.ty = 48'h6 | (48'h1 << 9) | (48'h5 << 45);
    sb_q.push_back(e);
    tick(1);
    wr_valid = 0;
    tick(2);
    frame_start = 1;
    tick(1);
    frame_start = 0;
    wait_drain("commit2");
    commit_req = 0;
    tick(1);

    // frame_start in IDLE is ignored even with a changed shadow entry
    wr_valid = 1; wr_index = 8'd3; wr_data = 32'h01C4_0200;
    tick(1);
    wr_valid = 0; frame_start = 1;
    tick(1);
    frame_start = 0;
    tick(1);
    check("fs_idle_x3", 160'(x_flat[39:30]), 160'(10'h014));
    check("fs_idle_count", 160'(commit_count), 160'(2));

    // cancelled commit: no swap
    commit_req = 1;
    tick(3);
    check("wr_ready_pending2", 160'(wr_ready), 160'(0));
    commit_req = 0;
    tick(1);
    frame_start = 1;
    tick(1);
    frame_start = 0;
    tick(1);
    check("cancel_count", 160'(commit_count), 160'(2));
    check("cancel_x3", 160'(x_flat[39:30]), 160'(10'h014));
    check("cancel_wr_ready", 160'(wr_ready), 160'(1));

    // commit into ACK, then reset while in ACK with commit_req still high
    e.cnt = 16'd3;
    e.x = 160'h155 | (160'h200 << 30) | (160'h3FF << 150);
    e.y = 160'h2AA | (160'h100 << 30) | (160'h001 << 150);
    e.st = 48'h2 | (48'h4 << 9) | (48'h7 << 45);
    e.ty = 48'h6 | (48'h3 << 9) | (48'h5 << 45);
    sb_q.push_back(e);
    commit_req = 1;
    tick(1);
    frame_start = 1;
    tick(1);
    frame_start = 0;
    wait_drain("commit3");
    Reset = 1;
    tick(1);
    check("ackrst_ack", 160'(commit_ack), 160'(0));
    check("ackrst_count", 160'(commit_count), 160'(0));
    check("ackrst_wr_ready", 160'(wr_ready), 160'(0));
    check("ackrst_err", 160'(err_count), 160'(0));
    check("ackrst_x", x_flat, 160'(0));
    check("ackrst_y", y_flat, 160'(0));
    check("ackrst_st_ty", 160'({st_flat, ty_flat}), 160'(0));
    e = '0;
    e.cnt = 16'd1;
    sb_q.push_back(e);
    Reset = 0;
    #1;
    check("wr_ready_release", 160'(wr_ready), 160'(1));
    tick(1);
    check("reenter_pending", 160'(wr_ready), 160'(0));
    frame_start = 1;
    tick(1);
    frame_start = 0;
    wait_drain("commit_after_reset");
    commit_req = 0;
    tick(1);

    // commit_count wrap: 65535 more commits from 1
    bulk = 1;
    frame_start = 1;
    repeat (65534) one_commit();
    check("count_ffff", 160'(commit_count), 160'(16'hFFFF));
    one_commit();
    check("count_wrap", 160'(commit_count), 160'(0));
    frame_start = 0;
    tick(1);
    bulk = 0;

    check("sb_empty", 160'(sb_q.size()), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_port_bank.md
SPRITE_PORT_BANK -- requirements
Module: sprite_port_bank

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 16, giving the number of sprite channels (legal range 2..64).
REQ-002 SHALL have derived parameter IDXW, default $clog2(NUM_SPRITES), giving the index width.
REQ-003 SHALL have port Clk, input, 1, the single clock; every register is clocked on the rising edge.
REQ-004 SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port wr_valid, input, 1, software write request.
REQ-006 SHALL have port wr_ready, output, 1, write accepted when wr_valid and wr_ready are both high.
REQ-007 SHALL have port wr_index, input, 8, target sprite channel.
REQ-008 SHALL have port wr_data, input, 32, packed entry: [9:0] x, [19:10] y, [22:20] state, [25:23] type, [31:26] ignored.
REQ-009 SHALL have port commit_req, input, 1, software request to publish the shadow bank (4-phase handshake).
REQ-010 SHALL have port commit_ack, output, 1, commit-done acknowledge.
REQ-011 SHALL have port frame_start, input, 1, one-cycle pulse at VGA vertical blank start.
REQ-012 SHALL have ports xCoord_flat, yCoord_flat, output, NUM_SPRITES*10, active coordinates; channel i sits at [10i+9:10i].
REQ-013 SHALL have ports state_flat, type_flat, output, NUM_SPRITES*3, active state and type per channel.
REQ-014 SHALL have port commit_count, output, 16, number of completed swaps.
REQ-015 SHALL have port err_count, output, 8, count of rejected writes.

Function
REQ-016 SHALL hold two banks, shadow (written by software) and active (driving the *_flat outputs), each NUM_SPRITES x 26 bits.
REQ-017 SHALL use FSM states IDLE, PENDING and ACK.
REQ-018 In IDLE: wr_ready=1 and commit_ack=0; commit_req=1 moves the FSM to PENDING on the next edge.
REQ-019 In PENDING: wr_ready=0 and commit_ack=0; the FSM waits for frame_start.
REQ-020 On a PENDING cycle with frame_start=1, the active bank SHALL be loaded from the shadow bank on that edge, commit_ack SHALL go to 1 and the FSM SHALL enter ACK, with outputs changing the cycle after the frame_start pulse.
REQ-021 In ACK: wr_ready=0 and commit_ack=1; commit_req=0 returns the FSM to IDLE and drops commit_ack on the next edge.
REQ-022 An accepted write with wr_index < NUM_SPRITES SHALL update the shadow entry on that edge and SHALL leave the active bank unchanged.
REQ-023 An accepted write with wr_index >= NUM_SPRITES SHALL be discarded and SHALL leave the shadow bank unchanged.
REQ-024 Writes and commit_req rising in the same IDLE cycle: the write SHALL be accepted and SHALL be included in the upcoming swap.
REQ-025 frame_start outside PENDING SHALL be ignored; the active bank never changes outside a swap.
REQ-026 The swap SHALL be atomic: all NUM_SPRITES channels update on the same edge.
REQ-027 commit_count SHALL increment by 1 per swap and wrap from 0xFFFF to 0x0000.
REQ-028 A commit_req deassert while in PENDING SHALL cancel the request (return to IDLE, no swap).

Reset
REQ-029 While Reset=1 at an edge, all shadow and active entries SHALL be cleared to 0, the FSM SHALL enter IDLE, and commit_ack, commit_count and err_count SHALL be cleared to 0.
REQ-030 During reset wr_ready SHALL read 0; it SHALL read 1 from the first cycle after reset release.
REQ-031 Reset SHALL override any operation in flight, including PENDING or ACK, with no swap; commit_req still high after release re-enters PENDING.

Configuration
REQ-032 Macro SPRITE_BANK_ERRCNT_EN defined: each discarded out-of-range write SHALL increment err_count, saturating at 0xFF.
REQ-033 Macro SPRITE_BANK_ERRCNT_EN undefined: err_count SHALL be constant 0 and discarded writes SHALL be silent; all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL cover: reset, then write idx 3 = 0x0080_6414 -> shadow updated, xCoord_flat[39:30] stays 0 until commit.
REQ-035 Bench SHALL cover: commit_req=1, frame_start pulse 10 cycles later -> ch3 x=0x014, y=0x019, state=0, type=1 appear the cycle after the pulse; commit_ack=1; commit_count=1.
REQ-036 Bench SHALL cover: wr_valid held during PENDING -> wr_ready=0 and no entry changes until return to IDLE.
REQ-037 Bench SHALL cover: write idx 16 with NUM_SPRITES=16 and macro on -> err_count=1 and banks unchanged; with macro off -> err_count=0.
REQ-038 Bench SHALL cover: commit_req dropped before frame_start -> no swap, commit_count unchanged; Reset asserted in ACK -> all outputs 0 next cycle.
REQ-039 Bench SHALL cover: 65536 commits -> commit_count wraps to 0; NUM_SPRITES=64 variant -> channel 63 mapped to xCoord_flat[639:630].
